// File: rtl/stim_bit_sequencer_pkg.sv
// Shared definitions for the stimulus bit sequencer: FSM state encoding and
// the width helper used to size counters and indices.
package stim_bit_sequencer_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PLAY = 1'b1
    } seq_state_e;

    // Smallest width able to index 'value' distinct items (0 for value <= 1).
    function automatic int stim_clog2(input int value);
        int w;
        w = 32'sd0;
        while ((32'sd1 << w) < value) begin
            w = w + 32'sd1;
        end
        return w;
    endfunction

endpackage

// File: rtl/stim_bit_sequencer_if.sv
// Control/stimulus bundle between a test controller (master) and the
// sequencer (slave), which drives the inverter input from bit_out.
interface stim_bit_sequencer_if
    import stim_bit_sequencer_pkg::*;
#(
    parameter int PATTERN_LEN = 12,
    parameter int IDX_W       = stim_clog2(PATTERN_LEN)
);
    logic                   start;
    logic                   stop;
    logic [PATTERN_LEN-1:0] pattern_in;
    logic                   repeat_en;
    logic                   idle_level;
    logic                   bit_out;
    logic                   bit_valid;
    logic [IDX_W-1:0]       bit_index;
    logic                   busy;
    logic                   done;

    modport master (
        output start, stop, pattern_in, repeat_en, idle_level,
        input  bit_out, bit_valid, bit_index, busy, done
    );

    modport slave (
        input  start, stop, pattern_in, repeat_en, idle_level,
        output bit_out, bit_valid, bit_index, busy, done
    );

endinterface

// File: rtl/stim_hold_timer.sv
// Load/enable down-counter that times how long each pattern bit is held;
// tc flags the last clock of the hold window.
module stim_hold_timer
    import stim_bit_sequencer_pkg::*;
#(
    parameter int  HOLD_CYCLES = 10,
    localparam int CNT_W       = stim_clog2(HOLD_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic tc
);

    logic [CNT_W-1:0] cnt_r;

    // Hold counter: reload on each new bit, count down while enabled, rest at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (load) begin
            cnt_r <= CNT_W'(HOLD_CYCLES - 1);
        end else if (en && (cnt_r != {CNT_W{1'b0}})) begin
            cnt_r <= cnt_r - CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign tc = (cnt_r == {CNT_W{1'b0}});

endmodule

// File: rtl/stim_bit_sequencer.sv
// Plays a captured bit pattern onto bit_out, one bit per HOLD_CYCLES clocks,
// in single-shot or looping mode. All outputs come straight from flops.
module stim_bit_sequencer
    import stim_bit_sequencer_pkg::*;
#(
    parameter int PATTERN_LEN = 12,
    parameter int HOLD_CYCLES = 10,
    parameter int IDX_W       = stim_clog2(PATTERN_LEN)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    stim_bit_sequencer_if.slave  bus
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PATTERN_LEN - 1);

    seq_state_e             state_r, state_s;
    logic [PATTERN_LEN-1:0] pat_r, pat_s;
    logic                   rep_r, rep_s;
    logic                   idle_r, idle_s;
    logic                   bit_out_r, bit_out_s;
    logic                   valid_r, valid_s;
    logic [IDX_W-1:0]       idx_r, idx_s;
    logic                   busy_r, busy_s;
    logic                   done_r, done_s;
    logic                   load_s, en_s, tc_s;

    stim_hold_timer #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_hold_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load_s),
        .en    (en_s),
        .tc    (tc_s)
    );

    // Next-state and next-output logic; the next bit is precomputed so bit_out stays a flop.
    always_comb begin
        state_s   = state_r;
        pat_s     = pat_r;
        rep_s     = rep_r;
        idle_s    = idle_r;
        bit_out_s = bit_out_r;
        valid_s   = valid_r;
        idx_s     = idx_r;
        busy_s    = busy_r;
        done_s    = 1'b0;
        load_s    = 1'b0;
        en_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    state_s   = ST_PLAY;
                    pat_s     = bus.pattern_in;
                    rep_s     = bus.repeat_en;
                    idle_s    = bus.idle_level;
                    bit_out_s = bus.pattern_in[0];
                    valid_s   = 1'b1;
                    idx_s     = {IDX_W{1'b0}};
                    busy_s    = 1'b1;
                    load_s    = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_PLAY: begin
                // Abort wins over everything else, including a concurrent start.
                if (bus.stop) begin
                    state_s   = ST_IDLE;
                    bit_out_s = idle_r;
                    valid_s   = 1'b0;
                    idx_s     = {IDX_W{1'b0}};
                    busy_s    = 1'b0;
                end else if (tc_s) begin
                    if (idx_r == LAST_IDX) begin
                        if (rep_r) begin
                            idx_s     = {IDX_W{1'b0}};
                            bit_out_s = pat_r[0];
                            load_s    = 1'b1;
                        end else begin
                            state_s   = ST_IDLE;
                            bit_out_s = idle_r;
                            valid_s   = 1'b0;
                            idx_s     = {IDX_W{1'b0}};
                            busy_s    = 1'b0;
                            done_s    = 1'b1;
                        end
                    end else begin
                        idx_s     = idx_r + IDX_W'(1);
                        bit_out_s = pat_r[idx_s];
                        load_s    = 1'b1;
                    end
                end else begin
                    en_s = 1'b1;
                end
            end
            default: begin
                state_s   = ST_IDLE;
                bit_out_s = idle_r;
                valid_s   = 1'b0;
                idx_s     = {IDX_W{1'b0}};
                busy_s    = 1'b0;
            end
        endcase
    end

    // State, captured configuration and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            pat_r     <= {PATTERN_LEN{1'b0}};
            rep_r     <= 1'b0;
            idle_r    <= 1'b0;
            bit_out_r <= 1'b0;
            valid_r   <= 1'b0;
            idx_r     <= {IDX_W{1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            pat_r     <= pat_s;
            rep_r     <= rep_s;
            idle_r    <= idle_s;
            bit_out_r <= bit_out_s;
            valid_r   <= valid_s;
            idx_r     <= idx_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
        end
    end

    assign bus.bit_out   = bit_out_r;
    assign bus.bit_valid = valid_r;
    assign bus.bit_index = idx_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;

endmodule

// File: tb/tb_stim_bit_sequencer.sv
// Directed bench: a 12-bit/10-clock sequencer and a 4-bit/1-clock sequencer,
// each driving a behavioural inverter, checked cycle by cycle against hand-derived values.
module tb_stim_bit_sequencer;
    import stim_bit_sequencer_pkg::*;

    localparam int L  = 12;
    localparam int H  = 10;
    localparam int SL = 4;
    localparam int SH = 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    stim_bit_sequencer_if #(.PATTERN_LEN(L))  mb ();
    stim_bit_sequencer_if #(.PATTERN_LEN(SL)) sb ();

    stim_bit_sequencer #(.PATTERN_LEN(L), .HOLD_CYCLES(H)) u_main (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (mb)
    );

    stim_bit_sequencer #(.PATTERN_LEN(SL), .HOLD_CYCLES(SH)) u_small (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sb)
    );

    // Inverters under test, fed by the sequencer outputs.
    logic inv_m, inv_s;
    assign inv_m = ~mb.bit_out;
    assign inv_s = ~sb.bit_out;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 'h%0h expected 'h%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_main_idle(input logic idl, input logic dn);
        chk("m_bit_idle", {31'd0, mb.bit_out},   {31'd0, idl});
        chk("m_valid0",   {31'd0, mb.bit_valid}, 32'd0);
        chk("m_busy0",    {31'd0, mb.busy},      32'd0);
        chk("m_idx0",     {28'd0, mb.bit_index}, 32'd0);
        chk("m_done",     {31'd0, mb.done},      {31'd0, dn});
    endtask

    // Expected main-instance outputs for cycle c after the accepting edge.
    task automatic check_main(input int c, input logic rep, input logic idl, input logic [L-1:0] pat);
        int   k;
        logic eb;
        if (rep || c <= L * H) begin
            k  = ((c - 1) / H) % L;
            eb = pat[k];
            chk("m_bit",   {31'd0, mb.bit_out},   {31'd0, eb});
            chk("m_idx",   {28'd0, mb.bit_index}, k);
            chk("m_valid", {31'd0, mb.bit_valid}, 32'd1);
            chk("m_busy",  {31'd0, mb.busy},      32'd1);
            chk("m_done",  {31'd0, mb.done},      32'd0);
            chk("m_inv",   {31'd0, inv_m},        {31'd0, ~eb});
        end else begin
            chk_main_idle(idl, (c == L * H + 1) ? 1'b1 : 1'b0);
        end
    endtask

    // Expected small-instance outputs for cycle c after the accepting edge.
    task automatic check_small(input int c, input logic idl, input logic [SL-1:0] pat);
        logic eb;
        if (c <= SL) begin
            eb = pat[c - 1];
            chk("s_bit",   {31'd0, sb.bit_out},   {31'd0, eb});
            chk("s_idx",   {30'd0, sb.bit_index}, c - 1);
            chk("s_valid", {31'd0, sb.bit_valid}, 32'd1);
            chk("s_busy",  {31'd0, sb.busy},      32'd1);
            chk("s_done",  {31'd0, sb.done},      32'd0);
            chk("s_inv",   {31'd0, inv_s},        {31'd0, ~eb});
        end else begin
            chk("s_bit_idle", {31'd0, sb.bit_out},   {31'd0, idl});
            chk("s_valid0",   {31'd0, sb.bit_valid}, 32'd0);
            chk("s_busy0",    {31'd0, sb.busy},      32'd0);
            chk("s_done",     {31'd0, sb.done},      (c == SL + 1) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        mb.start = 1'b0; mb.stop = 1'b0; mb.pattern_in = 12'h000;
        mb.repeat_en = 1'b0; mb.idle_level = 1'b0;
        sb.start = 1'b0; sb.stop = 1'b0; sb.pattern_in = 4'h0;
        sb.repeat_en = 1'b0; sb.idle_level = 1'b0;

        // Reset state.
        #12;
        chk_main_idle(1'b0, 1'b0);
        chk("s_rst_bit",  {31'd0, sb.bit_out},   32'd0);
        chk("s_rst_busy", {31'd0, sb.busy},      32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk_main_idle(1'b0, 1'b0);

        // Single-shot run; a mid-run start with new inputs must be ignored.
        mb.pattern_in = 12'hB6D; mb.repeat_en = 1'b0; mb.idle_level = 1'b0;
        mb.start = 1'b1;
        @(posedge clk); #1;
        mb.start = 1'b0;
        for (int c = 1; c <= 123; c++) begin
            check_main(c, 1'b0, 1'b0, 12'hB6D);
            if (c == 39) begin
                mb.start = 1'b1; mb.pattern_in = 12'h000;
                mb.idle_level = 1'b1; mb.repeat_en = 1'b1;
            end
            if (c == 40) mb.start = 1'b0;
            @(posedge clk); #1;
        end

        // Looping run, stop (with a simultaneous start) after cycle 150.
        mb.pattern_in = 12'hB6D; mb.repeat_en = 1'b1; mb.idle_level = 1'b1;
        mb.start = 1'b1;
        @(posedge clk); #1;
        mb.start = 1'b0; mb.idle_level = 1'b0;
        for (int c = 1; c <= 155; c++) begin
            if (c <= 150) check_main(c, 1'b1, 1'b1, 12'hB6D);
            else          chk_main_idle(1'b1, 1'b0);
            if (c == 150) begin mb.stop = 1'b1; mb.start = 1'b1; end
            if (c == 151) begin mb.stop = 1'b0; mb.start = 1'b0; end
            @(posedge clk); #1;
        end

        // Asynchronous reset in the middle of a bit, then a fresh replay.
        mb.repeat_en = 1'b0; mb.idle_level = 1'b0;
        mb.start = 1'b1;
        @(posedge clk); #1;
        mb.start = 1'b0;
        for (int c = 1; c <= 55; c++) begin
            check_main(c, 1'b0, 1'b0, 12'hB6D);
            if (c < 55) begin @(posedge clk); #1; end
        end
        #2 rst_n = 1'b0;
        #1;
        chk_main_idle(1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk_main_idle(1'b0, 1'b0);
        mb.start = 1'b1;
        @(posedge clk); #1;
        mb.start = 1'b0;
        for (int c = 1; c <= 122; c++) begin
            check_main(c, 1'b0, 1'b0, 12'hB6D);
            @(posedge clk); #1;
        end

        // One-clock hold; idle_level only takes effect once captured.
        sb.pattern_in = 4'b0101; sb.repeat_en = 1'b0; sb.idle_level = 1'b1;
        @(posedge clk); #1;
        chk("s_idle_uncaptured", {31'd0, sb.bit_out}, 32'd0);
        sb.start = 1'b1;
        @(posedge clk); #1;
        sb.start = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            check_small(c, 1'b1, 4'b0101);
            if (c == 5) sb.start = 1'b1;
            @(posedge clk); #1;
        end
        // Start accepted on the done cycle: back-to-back run.
        sb.start = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            check_small(c, 1'b1, 4'b0101);
            @(posedge clk); #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
